cmp_event_tracker: RTL and testbench
====================================

// Module: cmp_event_tracker
// PURPOSE
//   Consumes the agtb/aeqb/altb flags of the 4-bit magnitude comparator, one sample per in_valid.
//   Classifies each sample as BELOW / AT / ABOVE and debounces it: the state changes only after DEBOUNCE consecutive agreeing samples.
//   Emits single-cycle rise/fall pulses and a transition counter for downstream alarm/threshold logic.
// PARAMETERS
//   DEBOUNCE  3  consecutive agreeing valid samples needed to change state (legal >= 1)
//   CNT_W     8  width of the transition counter event_cnt
// PORTS
//   clk         in   1      single clock; all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      flags below are a sample this cycle
//   agtb        in   1      comparator a>b
//   aeqb        in   1      comparator a==b
//   altb        in   1      comparator a<b
//   state       out  2      debounced state: UNK=2'b00 BELOW=2'b01 AT=2'b10 ABOVE=2'b11
//   rise_pulse  out  1      1-cycle pulse; state moved to a higher rank
//   fall_pulse  out  1      1-cycle pulse; state moved to a lower rank
//   event_cnt   out  CNT_W  count of rise+fall events, saturating at all-ones
//   flag_err    out  1      flag triple was not one-hot on a valid sample
// BEHAVIOUR
//   - Reset: state=UNK, rise/fall=0, event_cnt=0, flag_err=0, internal cand=UNK, run=0. rst wins over in_valid.
//   - Only in_valid=1 cycles are samples. in_valid=0 cycles change nothing; gaps do not break a run.
//   - Category decode: {agtb,aeqb,altb} = 100->ABOVE, 010->AT, 001->BELOW. Any other pattern is illegal.
//     Illegal pattern: flag_err=1 for that cycle; cand/run/state untouched.
//   - Sample cat == state: run<=0.
//   - Sample cat != state, cat == cand: run<=run+1. Otherwise cand<=cat, run<=1.
//   - When the updated run value reaches DEBOUNCE, at that same edge: state<=cand and run<=0.
//     The new state is visible the cycle after the DEBOUNCE-th sample. DEBOUNCE=1 gives 1-cycle latency.
//   - Rank order: BELOW < AT < ABOVE. rise_pulse/fall_pulse are registered with the state change, high for exactly 1 cycle.
//     UNK->any state changes produce no pulse and no count.
//   - event_cnt += 1 on each rise or fall pulse and holds at 2^CNT_W-1 (never wraps).
//   - run width = $clog2(DEBOUNCE+1); run never exceeds DEBOUNCE.
//   - Reset mid-run discards partial runs; the next change again needs a full DEBOUNCE samples.
// CONFIGURATION
//   CMP_TRACK_ERR_HOLD_EN:
//     defined:   flag_err is sticky; set on the first illegal sample and cleared only by rst.
//     undefined: flag_err is a 1-cycle pulse per illegal sample.
// STRUCTURE
//   - cmp_track_pkg holds the 2-bit state encodings (UNK/BELOW/AT/ABOVE) and a rank-compare function.
//     It is shared with the bench.
//   - One sub-module, cmp_flag_decode: combinational flags -> {legal, category}.
//   - The top level holds the cand/run/state FSM, pulse registers and counter.
// TESTING (DEBOUNCE=3 unless noted)
//   - Reset, then 3 valid altb samples -> state=BELOW one cycle after the 3rd. No pulse, event_cnt=0.
//   - From BELOW, 3 valid agtb samples with in_valid=0 gaps between them -> state=ABOVE, rise_pulse high 1 cycle, event_cnt=1.
//   - From ABOVE, samples lt,lt,gt,lt,lt,lt -> state ABOVE until the 6th sample.
//     Then BELOW, fall_pulse 1 cycle, event_cnt=2.
//   - Flags 3'b110 on a valid cycle between two lt samples -> flag_err=1 (1 cycle, or held when CMP_TRACK_ERR_HOLD_EN).
//     The run continues, so one more lt completes the change.
//   - CNT_W=2, drive 5 alternating debounced transitions -> event_cnt sticks at 2'b11.
//   - 2 lt samples, then rst for 1 cycle -> state=UNK, event_cnt=0. Another 3 lt samples are needed for BELOW.

Source files
------------

// File: rtl/cmp_track_pkg.sv
// Shared encodings for the comparator event tracker: debounced state codes and rank ordering.
package cmp_track_pkg;

    typedef enum logic [1:0] {
        ST_UNK   = 2'b00,
        ST_BELOW = 2'b01,
        ST_AT    = 2'b10,
        ST_ABOVE = 2'b11
    } trk_state_e;

    // Encodings are chosen so that rank order matches numeric order (UNK never compared).
    function automatic logic rank_above(input trk_state_e a, input trk_state_e b);
        return (logic'(a > b));
    endfunction

endpackage

// File: rtl/cmp_flag_decode.sv
// Combinational decode of the comparator flag triple into a legal bit and a category.
import cmp_track_pkg::*;

module cmp_flag_decode (
    input  logic       agtb,
    input  logic       aeqb,
    input  logic       altb,
    output logic       legal,
    output trk_state_e cat
);

    always_comb begin
        legal = 1'b1;
        cat   = ST_UNK;
        unique case ({agtb, aeqb, altb})
            3'b100:  cat = ST_ABOVE;
            3'b010:  cat = ST_AT;
            3'b001:  cat = ST_BELOW;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_event_tracker.sv
// Debounced BELOW/AT/ABOVE tracker with rise/fall pulses and a saturating transition counter.
// Build option: define CMP_TRACK_ERR_HOLD_EN to make flag_err sticky until rst.
import cmp_track_pkg::*;

//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_UNK   | no debounced category yet (after reset)
//  ST_BELOW | DEBOUNCE agreeing a<b samples seen
//  ST_AT    | DEBOUNCE agreeing a==b samples seen
//  ST_ABOVE | DEBOUNCE agreeing a>b samples seen
module cmp_event_tracker #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             agtb,
    input  logic             aeqb,
    input  logic             altb,
    output logic [1:0]       state,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             flag_err
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);

    trk_state_e       state_q, state_d;
    trk_state_e       cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d, run_upd;
    logic             legal;
    trk_state_e       cat;
    logic             sample_ok;
    logic             rise_set, fall_set;

    cmp_flag_decode u_decode (
        .agtb  (agtb),
        .aeqb  (aeqb),
        .altb  (altb),
        .legal (legal),
        .cat   (cat)
    );

    assign sample_ok = in_valid & legal;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNK;
            cand_q  <= ST_UNK;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        run_upd = '0;
        if (sample_ok) begin
            if (cat == state_q) begin
                run_d = '0;
            end else begin
                if (cat == cand_q) begin
                    run_upd = run_q + 1'b1;
                end else begin
                    cand_d  = cat;
                    run_upd = RUN_W'(1);
                end
                // Commit on the DEBOUNCE-th agreeing sample and restart the run.
                if (run_upd == RUN_W'(DEBOUNCE)) begin
                    state_d = cand_d;
                    run_d   = '0;
                end else begin
                    run_d = run_upd;
                end
            end
        end
    end

    always_comb begin
        rise_set = 1'b0;
        fall_set = 1'b0;
        if (state_q != ST_UNK && state_d != state_q) begin
            rise_set = rank_above(state_d, state_q);
            fall_set = rank_above(state_q, state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            event_cnt  <= '0;
        end else begin
            rise_pulse <= rise_set;
            fall_pulse <= fall_set;
            if ((rise_set || fall_set) && event_cnt != '1)
                event_cnt <= event_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_err <= 1'b0;
        end else begin
`ifdef CMP_TRACK_ERR_HOLD_EN
            if (in_valid && !legal)
                flag_err <= 1'b1;
`else
            flag_err <= in_valid & ~legal;
`endif
        end
    end

endmodule

// File: tb/tb_cmp_event_tracker.sv
// Directed bench: three tracker instances (default, CNT_W=2, DEBOUNCE=1) driven by one stimulus stream.
module tb_cmp_event_tracker;

    localparam logic [2:0] LT  = 3'b001;
    localparam logic [2:0] EQ  = 3'b010;
    localparam logic [2:0] GT  = 3'b100;
    localparam logic [1:0] UNK = 2'b00, BELOW = 2'b01, AT = 2'b10, ABOVE = 2'b11;
`ifdef CMP_TRACK_ERR_HOLD_EN
    localparam logic ERR_AFTER = 1'b1;
`else
    localparam logic ERR_AFTER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, agtb, aeqb, altb;

    logic [1:0] state_a, state_b, state_c;
    logic       rise_a, rise_b, rise_c, fall_a, fall_b, fall_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;
    logic       err_a, err_b, err_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_event_tracker #(.DEBOUNCE(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agtb(agtb), .aeqb(aeqb), .altb(altb),
        .state(state_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .event_cnt(cnt_a), .flag_err(err_a)
    );

    cmp_event_tracker #(.DEBOUNCE(3), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agtb(agtb), .aeqb(aeqb), .altb(altb),
        .state(state_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .event_cnt(cnt_b), .flag_err(err_b)
    );

    cmp_event_tracker #(.DEBOUNCE(1), .CNT_W(8)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agtb(agtb), .aeqb(aeqb), .altb(altb),
        .state(state_c), .rise_pulse(rise_c), .fall_pulse(fall_c), .event_cnt(cnt_c), .flag_err(err_c)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one valid sample, returns at the next negedge.
    task automatic sample(input logic [2:0] f);
        in_valid = 1'b1;
        {agtb, aeqb, altb} = f;
        @(negedge clk);
        in_valid = 1'b0;
        {agtb, aeqb, altb} = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; {agtb, aeqb, altb} = 3'b000;
        idle(2);
        rst = 1'b0;
        check("rst_state", {6'd0, state_a}, {6'd0, UNK});
        check("rst_rise", {7'd0, rise_a}, 8'd0);
        check("rst_fall", {7'd0, fall_a}, 8'd0);
        check("rst_cnt", cnt_a, 8'd0);
        check("rst_err", {7'd0, err_a}, 8'd0);

        // illegal flags without in_valid are not samples
        {agtb, aeqb, altb} = 3'b110;
        idle(1);
        {agtb, aeqb, altb} = 3'b000;
        check("noval_err", {7'd0, err_a}, 8'd0);

        // UNK -> BELOW, no pulse
        sample(LT);
        check("d1_first_below", {6'd0, state_c}, {6'd0, BELOW});
        check("d1_no_pulse_unk", {6'd0, rise_c, fall_c}, 8'd0);
        check("lt1_unk", {6'd0, state_a}, {6'd0, UNK});
        sample(LT);
        check("lt2_unk", {6'd0, state_a}, {6'd0, UNK});
        sample(LT);
        check("lt3_below", {6'd0, state_a}, {6'd0, BELOW});
        check("lt3_pulses", {6'd0, rise_a, fall_a}, 8'd0);
        check("lt3_cnt", cnt_a, 8'd0);

        // BELOW -> ABOVE with gaps between samples
        sample(GT);
        check("d1_gt_above", {6'd0, state_c}, {6'd0, ABOVE});
        check("d1_gt_rise", {7'd0, rise_c}, 8'd1);
        idle(2);
        sample(GT);
        idle(1);
        check("gt2_below", {6'd0, state_a}, {6'd0, BELOW});
        sample(GT);
        check("gt3_above", {6'd0, state_a}, {6'd0, ABOVE});
        check("gt3_rise", {7'd0, rise_a}, 8'd1);
        check("gt3_fall", {7'd0, fall_a}, 8'd0);
        check("gt3_cnt", cnt_a, 8'd1);
        idle(1);
        check("gt3_rise_gone", {7'd0, rise_a}, 8'd0);

        // agreeing sample resets the run
        sample(LT);
        sample(LT);
        sample(GT);
        sample(LT);
        sample(LT);
        check("mix5_above", {6'd0, state_a}, {6'd0, ABOVE});
        sample(LT);
        check("mix6_below", {6'd0, state_a}, {6'd0, BELOW});
        check("mix6_fall", {6'd0, rise_a, fall_a}, 8'd1);
        check("mix6_cnt", cnt_a, 8'd2);
        check("d1_mix_cnt", cnt_c, 8'd4);
        idle(1);
        check("mix6_fall_gone", {7'd0, fall_a}, 8'd0);

        // BELOW -> AT: third event, narrow counter reaches 2'b11
        sample(EQ); sample(EQ); sample(EQ);
        check("eq_at", {6'd0, state_a}, {6'd0, AT});
        check("eq_cnt", cnt_a, 8'd3);
        check("c2_cnt3", {6'd0, cnt_b}, 8'd3);

        // illegal sample mid-run does not break it
        sample(LT);
        sample(3'b110);
        check("ill_err", {7'd0, err_a}, 8'd1);
        check("ill_state", {6'd0, state_a}, {6'd0, AT});
        sample(LT);
        check("ill_err_after", {7'd0, err_a}, {7'd0, ERR_AFTER});
        check("ill_still_at", {6'd0, state_a}, {6'd0, AT});
        sample(LT);
        check("ill_below", {6'd0, state_a}, {6'd0, BELOW});
        check("ill_fall", {7'd0, fall_a}, 8'd1);
        check("ill_cnt", cnt_a, 8'd4);
        check("c2_sat4", {6'd0, cnt_b}, 8'd3);
        check("d1_ill_cnt", cnt_c, 8'd6);

        sample(GT); sample(GT); sample(GT);
        check("gt_above5", {6'd0, state_a}, {6'd0, ABOVE});
        check("cnt5", cnt_a, 8'd5);
        check("c2_sat5", {6'd0, cnt_b}, 8'd3);
        check("c2_rise5", {7'd0, rise_b}, 8'd1);

        // reset mid-run, with a valid sample competing against rst
        sample(LT);
        sample(LT);
        rst = 1'b1; in_valid = 1'b1; {agtb, aeqb, altb} = LT;
        idle(1);
        rst = 1'b0; in_valid = 1'b0; {agtb, aeqb, altb} = 3'b000;
        check("mrst_state", {6'd0, state_a}, {6'd0, UNK});
        check("mrst_cnt", cnt_a, 8'd0);
        check("mrst_c2_cnt", {6'd0, cnt_b}, 8'd0);
        check("mrst_d1_state", {6'd0, state_c}, {6'd0, UNK});
        check("mrst_err", {7'd0, err_a}, 8'd0);

        sample(3'b000);
        check("zero_err", {7'd0, err_a}, 8'd1);
        sample(LT);
        sample(LT);
        check("post_lt2_unk", {6'd0, state_a}, {6'd0, UNK});
        sample(LT);
        check("post_lt3_below", {6'd0, state_a}, {6'd0, BELOW});
        check("post_pulses", {6'd0, rise_a, fall_a}, 8'd0);
        check("post_cnt", cnt_a, 8'd0);
        check("post_err", {7'd0, err_a}, {7'd0, ERR_AFTER});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
